// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative WIDTH-bit multiply/divide unit owning the HI/LO pair.
// Multiply is shift-add over magnitudes, divide is restoring shift-subtract;
// sign correction is applied once in FINISH.
module mul_div_unit #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div;
  logic               div_zero;
  logic               neg_result;
  logic               neg_rem;

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               last_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;
  assign last_step = (count == CW'(WIDTH - 1));

  // Per-iteration arithmetic plus the final sign correction of the magnitude result
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, operand};
    div_ok    = ~div_diff[WIDTH+1];
    prod_fix  = neg_result ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quot_fix  = neg_result ? -acc_lo : acc_lo;
    rem_fix   = neg_rem ? -acc_hi : acc_hi;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH steps, FINISH for one cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_step) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration registers, HI/LO writes and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      operand    <= '0;
      a_raw      <= '0;
      is_div     <= 1'b0;
      div_zero   <= 1'b0;
      neg_result <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            is_div     <= op[1];
            count      <= '0;
            acc_hi     <= '0;
            acc_lo     <= op[1] ? mag_a : mag_b;
            operand    <= op[1] ? mag_b : mag_a;
            a_raw      <= a;
            div_zero   <= op[1] & (b == '0);
            neg_result <= a_neg ^ b_neg;
            neg_rem    <= a_neg;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (div_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
